// File: rtl/seq_div.sv
// Multi-cycle unsigned restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// Optional zero-divisor short cut enabled by defining SEQ_DIV_ZERO_CHECK_EN.
module seq_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] y,
    input  logic [7:0]  b,
    output logic [15:0] q,
    output logic [7:0]  r,
    output logic        busy,
    output logic        done,
    output logic        dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [8:0]  pr_q, pr_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [15:0] q_q, q_d;
    logic [7:0]  r_q, r_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [8:0]  pr_shift;
    logic        q_bit;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    logic        zero_q, zero_d;
    logic        dz_q, dz_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pr_d     = pr_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        q_d      = q_q;
        r_d      = r_q;
        done_d   = 1'b0;
        pr_shift = {pr_q[7:0], dvd_q[15]};
        q_bit    = (pr_shift >= {1'b0, dvs_q});
`ifdef SEQ_DIV_ZERO_CHECK_EN
        zero_d   = zero_q;
        dz_d     = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = y;
                    dvs_d   = b;
                    pr_d    = 9'd0;
                    cnt_d   = 4'd0;
                    state_d = S_RUN;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                    zero_d  = 1'b0;
                    // Preload exactly what the full iteration would produce for b==0.
                    if (b == 8'd0) begin
                        dvd_d   = 16'hFFFF;
                        pr_d    = {1'b0, y[7:0]};
                        zero_d  = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                pr_d  = q_bit ? (pr_shift - {1'b0, dvs_q}) : pr_shift;
                dvd_d = {dvd_q[14:0], q_bit};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                q_d     = dvd_q;
                r_d     = pr_q[7:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef SEQ_DIV_ZERO_CHECK_EN
                dz_d    = zero_q;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef SEQ_DIV_ZERO_CHECK_EN
        busy_d = (state_d == S_RUN) || ((state_d == S_DONE) && !zero_d);
`else
        busy_d = (state_d == S_RUN) || (state_d == S_DONE);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            pr_q    <= 9'd0;
            dvd_q   <= 16'd0;
            dvs_q   <= 8'd0;
            q_q     <= 16'd0;
            r_q     <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            zero_q  <= zero_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign q    = q_q;
    assign r    = r_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    assign dz   = dz_q;
`else
    assign dz   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed table, random reference-model runs, handshake and reset corners.
module tb_seq_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] y;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        busy;
    logic        done;
    logic        dz;

    int n_vec;
    int n_bad;

    seq_div dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .y     (y),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] y;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
    } vec_t;

`ifdef SEQ_DIV_ZERO_CHECK_EN
    localparam int ZLAT = 1;
    localparam logic ZDZ = 1'b1;
`else
    localparam int ZLAT = 17;
    localparam logic ZDZ = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the documented divide-by-zero result.
    task automatic model(input logic [15:0] yy, input logic [7:0] bb,
                         output logic [15:0] qq, output logic [7:0] rr);
        int unsigned yi, bi;
        yi = yy;
        bi = bb;
        if (bi == 0) begin
            qq = 16'hFFFF;
            rr = yy[7:0];
        end else begin
            qq = 16'(yi / bi);
            rr = 8'(yi % bi);
        end
    endtask

    // Entered and left #1 after a rising edge.
    task automatic do_div(input logic [15:0] yy, input logic [7:0] bb,
                          input logic [15:0] eq, input logic [7:0] er,
                          input logic edz, input int elat);
        int lat;
        lat = 0;
        y = yy;
        b = bb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", busy, (elat > 1));
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 8) chk("busy_mid", busy, (elat > 8));
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, elat);
        chk("q", q, eq);
        chk("r", r, er);
        chk("dz", dz, edz);
        chk("busy_at_done", busy, 1'b0);
        $display("op y=%04h b=%02h -> q=%04h r=%02h dz=%0b lat=%0d", yy, bb, q, r, dz, lat);
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
    endtask

    vec_t vecs[7];
    logic [15:0] mq;
    logic [7:0]  mr;
    int lat2;

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        y     = 16'd0;
        b     = 8'd0;

        vecs[0] = '{16'h0004, 8'h02, 16'h0002, 8'h00};
        vecs[1] = '{16'h4000, 8'h80, 16'h0080, 8'h00};
        vecs[2] = '{16'hFE01, 8'hFF, 16'h00FF, 8'h00};
        vecs[3] = '{16'h03E8, 8'h07, 16'h008E, 8'h06};
        vecs[4] = '{16'h00FF, 8'hFF, 16'h0001, 8'h00};
        vecs[5] = '{16'h0005, 8'h09, 16'h0000, 8'h05};
        vecs[6] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_q", q, 16'd0);
        chk("rst_r", r, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_dz", dz, 1'b0);

        for (int i = 0; i < 7; i++) begin
            do_div(vecs[i].y, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0, 17);
        end

        // Inverse of an 8x8 multiply: the product divided by one factor gives the other.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] aa, bb;
            aa = 8'($urandom_range(0, 255));
            bb = 8'($urandom_range(1, 255));
            do_div(16'(aa) * 16'(bb), bb, 16'(aa), 8'h00, 1'b0, 17);
        end

        for (int i = 0; i < 48; i++) begin
            logic [15:0] yy;
            logic [7:0]  bb;
            yy = 16'($urandom);
            bb = 8'($urandom_range(1, 255));
            model(yy, bb, mq, mr);
            do_div(yy, bb, mq, mr, 1'b0, 17);
        end

        // Divide by zero.
        model(16'h1234, 8'h00, mq, mr);
        do_div(16'h1234, 8'h00, mq, mr, ZDZ, ZLAT);
        chk("dz_hold", dz, ZDZ);

        // start pulses during RUN and the done cycle must be ignored.
        y = 16'h03E8;
        b = 8'h07;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            if (i == 4 || i == 16) begin
                y = 16'hFFFF;
                b = 8'h01;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("hs_done", done, 1'b1);
        chk("hs_q", q, 16'h008E);
        chk("hs_r", r, 8'h06);
        $display("op handshake y=03e8 b=07 -> q=%04h r=%02h", q, r);
        @(posedge clk); #1;
        chk("hs_no_retrigger", busy, 1'b0);
        @(posedge clk); #1;
        chk("hs_still_idle", busy, 1'b0);

        // start held high: re-accepted in the IDLE cycle after done, 18-cycle period.
        y = 16'h0064;
        b = 8'h0A;
        start = 1'b1;
        @(posedge clk); #1;
        lat2 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat2 = i;
                break;
            end
        end
        chk("held_first_latency", lat2, 17);
        @(posedge clk); #1;
        start = 1'b0;
        chk("held_reaccept_busy", busy, 1'b1);
        lat2 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat2 = i;
                break;
            end
        end
        chk("held_period", lat2 + 1, 18);
        chk("held_q", q, 16'h000A);
        $display("op held-start period=%0d q=%04h", lat2 + 1, q);
        @(posedge clk); #1;

        // Reset during iteration 8 discards the operation.
        y = 16'h03E8;
        b = 8'h07;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_q", q, 16'd0);
        chk("mid_rst_r", r, 8'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_dz", dz, 1'b0);
        $display("op reset mid-operation q=%04h busy=%0b", q, busy);
        do_div(16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_div.md
# seq_div

Multi-cycle unsigned restoring divider: 16-bit dividend by 8-bit divisor, giving a 16-bit quotient and an 8-bit remainder. It is the inverse of the combinational 8x8 `mul` block in the arith library: a product `y` from `mul`, divided by either operand, returns the other operand with remainder 0. One quotient bit is resolved per clock, and a start/busy/done handshake sequences each operation.

## Interface
- Parameters: none. Widths are fixed: dividend 16, divisor 8, quotient 16, remainder 8.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `y`  in  16  dividend; captured on an accepted start.
- `b`  in  8  divisor; captured on an accepted start.
- `q`  out  16  quotient; registered.
- `r`  out  8  remainder; registered.
- `busy`  out  1  high while iterating (RUN).
- `done`  out  1  one-cycle pulse; `q`/`r`/`dz` are valid.
- `dz`  out  1  divide-by-zero flag; valid with `done`.

## Operation
- States:
  - IDLE:
    - Default state after reset.
    - `start=1` captures `y`/`b`, clears the partial remainder `pr` (9 bits) and the iteration counter, then goes to RUN.
  - RUN:
    - 16 iterations, one per cycle, MSB of the dividend first.
    - Each iteration: `pr = {pr[7:0], next dividend bit}`. If `pr >= {1'b0,b}`, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
    - After the 16th iteration, go to DONE.
  - DONE:
    - `done=1` for exactly one cycle; `q` and `r = pr[7:0]` are valid.
    - Next state is always IDLE.
- `start` is ignored in RUN and DONE; there is no queuing.
- `q`, `r` and `dz` hold their last values through IDLE until the next operation completes.
- Width rules:
  - All arithmetic is unsigned.
  - The 9-bit partial remainder prevents the compare from overflowing when `b >= 0x80`.
  - The quotient never overflows 16 bits.
- Divide by zero without the check feature: the algorithm runs normally and yields `q=16'hFFFF`, `r=y[7:0]`, `dz=0`.
- Reset:
  - `rst=1` at any edge forces IDLE.
  - Clears `q`, `r`, `busy`, `done` and `dz` to 0.
  - Discards any in-flight operation; `rst` has priority over `start`.

## Timing
- Reset values: `q=0`, `r=0`, `busy=0`, `done=0`, `dz=0`.
- Start accepted at edge N:
  - `busy=1` from N through the edge that completes iteration 16 (N+16).
  - `done=1` during the cycle after edge N+17.
  - Total latency is 17 cycles from the accepting edge to the `done` edge.
- Earliest back-to-back start is sampled in the IDLE cycle following DONE. This gives a throughput of one result per 18 cycles.
- `start` held continuously high is re-accepted in each IDLE cycle. It does not retrigger during RUN or DONE.
- Outputs change only on clock edges; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SEQ_DIV_ZERO_CHECK_EN`.
- Defined:
  - A start with `b==0` goes IDLE→DONE directly, with a latency of 1 cycle.
  - Results: `q=16'hFFFF`, `r=y[7:0]`, `dz=1`. These values are identical to the unchecked result apart from `dz`.
  - `busy` stays 0 for this operation.
  - `dz=0` for all nonzero divisors.
- Undefined:
  - No zero detection; every operation takes the full 17 cycles.
  - `dz` is tied to 0; the port remains present.

## Test plan
- Basic and exact divisions, with `rst` pulsed first:
  - `y=16'h0004, b=8'h02` → `q=16'h0002`, `r=8'h00`.
  - `y=16'h4000, b=8'h80` → `q=16'h0080`, `r=8'h00`.
  - `y=16'hFE01, b=8'hFF` → `q=16'h00FF`, `r=8'h00`.
  - Each result is checked exactly 17 cycles after acceptance, with `done` high for 1 cycle.
- Nonzero remainder and large divisor:
  - `y=16'h03E8, b=8'h07` → `q=16'h008E`, `r=8'h06`.
  - `y=16'h00FF, b=8'hFF` → `q=16'h0001`, `r=8'h00`.
  - `y=16'h0005, b=8'h09` → `q=16'h0000`, `r=8'h05`.
- `mul` round trip: 256 random (a, b≠0) pairs, feeding `y=a*b` → `q=a`, `r=0`.
- Handshake:
  - `start` pulsed during RUN and during DONE → ignored; the result matches the first operands.
  - `start` held high → a new operation is accepted in the IDLE cycle after DONE, giving an 18-cycle period.
- Reset mid-operation: `rst` asserted at iteration 8 → next cycle all outputs are 0 and the state is IDLE. A subsequent `y=16'h0064, b=8'h0A` gives `q=16'h000A`, `r=0`.
- Divide by zero, `y=16'h1234, b=8'h00`:
  - With the macro: `done` 1 cycle after acceptance, `q=16'hFFFF`, `r=8'h34`, `dz=1`.
  - Without the macro: same `q`/`r` after 17 cycles, `dz=0`.
